// File: rtl/packet_snooper_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | packet_snooper_if : stream-in / RAM-write-out bundle for snooper    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface packet_snooper_if #(
   parameter int PORT_ADDR_WIDTH = 10,
   parameter int PORT_DATA_WIDTH = 32
);
   logic                           mem_ready;
   logic [PORT_DATA_WIDTH-1:0]     in_data;
   logic                           in_valid;
   logic                           in_last;
   logic                           in_ready;
   logic [PORT_ADDR_WIDTH-1:0]     wr_addr;
   logic [2*PORT_DATA_WIDTH-1:0]   wr_data;
   logic                           wr_en;
   logic                           len_rst;
   logic                           done;
   logic [PORT_ADDR_WIDTH:0]       pkt_words;
   logic                           overflow;

   modport master (
      output mem_ready, in_data, in_valid, in_last,
      input  in_ready, wr_addr, wr_data, wr_en, len_rst, done, pkt_words, overflow
   );

   modport slave (
      input  mem_ready, in_data, in_valid, in_last,
      output in_ready, wr_addr, wr_data, wr_en, len_rst, done, pkt_words, overflow
   );
endinterface
`default_nettype wire

// File: rtl/packet_snooper.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | packet_snooper : packs 32-bit word pairs into 64-bit RAM writes     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module packet_snooper #(
   parameter int PORT_ADDR_WIDTH = 10,
   parameter int PORT_DATA_WIDTH = 32
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   packet_snooper_if.slave bus
);
   localparam int DEPTH = 2**PORT_ADDR_WIDTH;
   localparam logic [PORT_ADDR_WIDTH-1:0] c_LAST_PAIR  = PORT_ADDR_WIDTH'(DEPTH - 2);
   localparam logic [PORT_ADDR_WIDTH:0]   c_DEPTH_WORDS = (PORT_ADDR_WIDTH + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVEN = 2'd1,
      ODD  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t                         r_state;
   state_t                         w_next;
   logic                           w_ready;
   logic                           w_beat;
   logic [PORT_ADDR_WIDTH-1:0]     r_addr;
   logic                           r_full;
   logic [PORT_DATA_WIDTH-1:0]     r_hold;
   logic [PORT_ADDR_WIDTH-1:0]     r_wr_addr;
   logic [2*PORT_DATA_WIDTH-1:0]   r_wr_data;
   logic                           r_wr_en;
   logic                           r_len_rst;
   logic [PORT_ADDR_WIDTH:0]       r_pkt_words;
   logic                           r_overflow;

   assign w_ready = (r_state == EVEN) || (r_state == ODD);
   assign w_beat  = bus.in_valid && w_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (bus.mem_ready) w_next = EVEN;
         EVEN: if (w_beat) w_next = bus.in_last ? DONE : ODD;
         ODD:  if (w_beat) w_next = bus.in_last ? DONE : EVEN;
         DONE: if (!bus.mem_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr      <= '0;
         r_full      <= 1'b0;
         r_hold      <= '0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_wr_en     <= 1'b0;
         r_len_rst   <= 1'b0;
         r_pkt_words <= '0;
         r_overflow  <= 1'b0;
      end else begin
         r_wr_en   <= 1'b0;
         r_len_rst <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.mem_ready) begin
                  r_len_rst   <= 1'b1;
                  r_addr      <= '0;
                  r_full      <= 1'b0;
                  r_wr_addr   <= '0;
                  r_pkt_words <= '0;
                  r_overflow  <= 1'b0;
               end
            end
            EVEN: begin
               if (w_beat) begin
                  if (r_full) begin
                     r_overflow <= 1'b1;
                  end else if (bus.in_last) begin
                     r_wr_en   <= 1'b1;
                     r_wr_addr <= r_addr;
                     r_wr_data <= {bus.in_data, {PORT_DATA_WIDTH{1'b0}}};
                  end else begin
                     r_hold <= bus.in_data;
                  end
               end
            end
            ODD: begin
               if (w_beat) begin
                  if (r_full) begin
                     r_overflow <= 1'b1;
                  end else begin
                     r_wr_en   <= 1'b1;
                     r_wr_addr <= r_addr;
                     r_wr_data <= {r_hold, bus.in_data};
                     // The top pair is the last writable slot; freeze instead of wrapping.
                     if (r_addr == c_LAST_PAIR) begin
                        r_full <= 1'b1;
                     end else begin
                        r_addr <= r_addr + PORT_ADDR_WIDTH'(2);
                     end
                  end
               end
            end
            default: ;
         endcase
         if (w_beat && (r_pkt_words != c_DEPTH_WORDS)) begin
            r_pkt_words <= r_pkt_words + 1'b1;
         end
      end
   end

   assign bus.in_ready  = w_ready;
   assign bus.wr_addr   = r_wr_addr;
   assign bus.wr_data   = r_wr_data;
   assign bus.wr_en     = r_wr_en;
   assign bus.len_rst   = r_len_rst;
   // Held off while the final write strobe is still on the bus.
   assign bus.done      = (r_state == DONE) && !r_wr_en;
   assign bus.pkt_words = r_pkt_words;
   assign bus.overflow  = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_packet_snooper.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_packet_snooper : directed bench, DEPTH=8 and DEPTH=1024 copies   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_packet_snooper;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_ready = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic [31:0] in_data = '0;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          lens = 0;

   typedef struct {
      int          a;
      logic [63:0] d;
      int          c;
   } wr_t;
   wr_t qs[$];
   wr_t qb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   packet_snooper_if #(.PORT_ADDR_WIDTH(3),  .PORT_DATA_WIDTH(32)) ifs();
   packet_snooper_if #(.PORT_ADDR_WIDTH(10), .PORT_DATA_WIDTH(32)) ifb();

   assign ifs.mem_ready = mem_ready;
   assign ifs.in_valid  = in_valid;
   assign ifs.in_last   = in_last;
   assign ifs.in_data   = in_data;
   assign ifb.mem_ready = mem_ready;
   assign ifb.in_valid  = in_valid;
   assign ifb.in_last   = in_last;
   assign ifb.in_data   = in_data;

   packet_snooper #(.PORT_ADDR_WIDTH(3), .PORT_DATA_WIDTH(32)) u_small (
      .clk(clk), .rst_n(rst_n), .bus(ifs)
   );
   packet_snooper #(.PORT_ADDR_WIDTH(10), .PORT_DATA_WIDTH(32)) u_big (
      .clk(clk), .rst_n(rst_n), .bus(ifb)
   );

   always @(negedge clk) begin
      if (ifs.wr_en) qs.push_back('{int'(ifs.wr_addr), ifs.wr_data, cyc});
      if (ifb.wr_en) qb.push_back('{int'(ifb.wr_addr), ifb.wr_data, cyc});
      if (ifs.len_rst) lens++;
   end

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_s(input string tag, input int i, input int a, input logic [63:0] d);
      if (i < qs.size()) begin
         check({tag, "_addr"}, 80'(qs[i].a), 80'(a));
         check({tag, "_data"}, 80'(qs[i].d), 80'(d));
      end else begin
         total++; bad++;
         $error("FAIL %s observed=missing expected=write %0d", tag, i);
      end
   endtask

   task automatic chk_b(input string tag, input int i, input int a, input logic [63:0] d);
      if (i < qb.size()) begin
         check({tag, "_addr"}, 80'(qb[i].a), 80'(a));
         check({tag, "_data"}, 80'(qb[i].d), 80'(d));
      end else begin
         total++; bad++;
         $error("FAIL %s observed=missing expected=write %0d", tag, i);
      end
   endtask

   // Called on a negedge; returns on the negedge after the accepting posedge.
   task automatic send(input logic [31:0] d, input logic last);
      int n = 0;
      in_valid = 1'b1; in_data = d; in_last = last;
      while (!ifs.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!ifs.in_ready) begin
         total++; bad++;
         $error("FAIL send_timeout observed=in_ready 0 expected=in_ready 1");
      end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic release_mem();
      mem_ready = 1'b0;
      @(negedge clk);
      qs.delete(); qb.delete(); lens = 0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_in_ready",  80'(ifs.in_ready),  80'(0));
      check("rst_wr_en",     80'(ifs.wr_en),     80'(0));
      check("rst_len_rst",   80'(ifs.len_rst),   80'(0));
      check("rst_done",      80'(ifs.done),      80'(0));
      check("rst_overflow",  80'(ifs.overflow),  80'(0));
      check("rst_wr_addr",   80'(ifs.wr_addr),   80'(0));
      check("rst_wr_data",   80'(ifs.wr_data),   80'(0));
      check("rst_pkt_words", 80'(ifb.pkt_words), 80'(0));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_in_ready", 80'(ifs.in_ready), 80'(0));
      check("idle_len_rst",  80'(lens),         80'(0));

      // four-word packet, in_valid held high
      mem_ready = 1'b1;
      send(32'hA000_000A, 1'b0);
      send(32'hB000_000B, 1'b0);
      send(32'hC000_000C, 1'b0);
      send(32'hD000_000D, 1'b1);
      check("p1_strobe_wr_en", 80'(ifs.wr_en), 80'(1));
      check("p1_strobe_done",  80'(ifs.done),  80'(0));
      @(negedge clk);
      check("p1_done",      80'(ifs.done),      80'(1));
      check("p1_in_ready",  80'(ifs.in_ready),  80'(0));
      check("p1_pkt_words", 80'(ifs.pkt_words), 80'(4));
      check("p1_overflow",  80'(ifs.overflow),  80'(0));
      check("p1_len_rst",   80'(lens),          80'(1));
      check("p1_nwrites",   80'(qs.size()),     80'(2));
      chk_s("p1_w0", 0, 0, {32'hA000_000A, 32'hB000_000B});
      chk_s("p1_w1", 1, 2, {32'hC000_000C, 32'hD000_000D});
      if (qs.size() == 2) check("p1_spacing", 80'(qs[1].c - qs[0].c), 80'(2));
      repeat (3) @(negedge clk);
      check("p1_done_hold",  80'(ifs.done),      80'(1));
      check("p1_words_hold", 80'(ifs.pkt_words), 80'(4));
      release_mem();
      check("p1_idle_done",  80'(ifs.done),     80'(0));
      check("p1_idle_ready", 80'(ifs.in_ready), 80'(0));

      // three-word packet with gaps on in_valid
      mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      send(32'h1111_0001, 1'b0);
      repeat (2) @(negedge clk);
      check("p2_ready_no_valid", 80'(ifs.in_ready), 80'(1));
      send(32'h2222_0002, 1'b0);
      repeat (3) @(negedge clk);
      send(32'h3333_0003, 1'b1);
      @(negedge clk);
      check("p2_done",      80'(ifs.done),      80'(1));
      check("p2_pkt_words", 80'(ifs.pkt_words), 80'(3));
      check("p2_overflow",  80'(ifs.overflow),  80'(0));
      check("p2_len_rst",   80'(lens),          80'(1));
      check("p2_nwrites",   80'(qs.size()),     80'(2));
      chk_s("p2_w0", 0, 0, {32'h1111_0001, 32'h2222_0002});
      chk_s("p2_w1", 1, 2, {32'h3333_0003, 32'h0});
      release_mem();

      // single-word packet
      mem_ready = 1'b1;
      send(32'h5EED_0001, 1'b1);
      check("p3_strobe_wr_en", 80'(ifs.wr_en), 80'(1));
      check("p3_strobe_done",  80'(ifs.done),  80'(0));
      @(negedge clk);
      check("p3_done",      80'(ifs.done),      80'(1));
      check("p3_pkt_words", 80'(ifs.pkt_words), 80'(1));
      check("p3_nwrites",   80'(qs.size()),     80'(1));
      chk_s("p3_w0", 0, 0, {32'h5EED_0001, 32'h0});
      release_mem();

      // ten-word packet: overflows DEPTH=8, fits DEPTH=1024
      mem_ready = 1'b1;
      for (int i = 0; i < 10; i++) send(32'h1000 + i, (i == 9));
      repeat (2) @(negedge clk);
      check("p4_s_nwrites",   80'(qs.size()),     80'(4));
      for (int k = 0; k < 4; k++)
         chk_s("p4_s_w", k, 2 * k, {32'h1000 + 2 * k, 32'h1000 + 2 * k + 1});
      check("p4_s_overflow",  80'(ifs.overflow),  80'(1));
      check("p4_s_pkt_words", 80'(ifs.pkt_words), 80'(8));
      check("p4_s_done",      80'(ifs.done),      80'(1));
      check("p4_b_nwrites",   80'(qb.size()),     80'(5));
      chk_b("p4_b_w4", 4, 8, {32'h1008, 32'h1009});
      check("p4_b_overflow",  80'(ifb.overflow),  80'(0));
      check("p4_b_pkt_words", 80'(ifb.pkt_words), 80'(10));
      release_mem();

      // next packet clears overflow
      mem_ready = 1'b1;
      send(32'h7777_0001, 1'b0);
      send(32'h7777_0002, 1'b1);
      @(negedge clk);
      check("p5_overflow",  80'(ifs.overflow),  80'(0));
      check("p5_pkt_words", 80'(ifs.pkt_words), 80'(2));
      check("p5_nwrites",   80'(qs.size()),     80'(1));
      chk_s("p5_w0", 0, 0, {32'h7777_0001, 32'h7777_0002});
      release_mem();

      // reset mid-packet after three beats
      mem_ready = 1'b1;
      send(32'h9999_0001, 1'b0);
      send(32'h9999_0002, 1'b0);
      send(32'h9999_0003, 1'b0);
      check("p6_pre_pkt_words", 80'(ifs.pkt_words), 80'(3));
      rst_n = 1'b0;
      #1;
      check("p6_rst_in_ready",  80'(ifs.in_ready),  80'(0));
      check("p6_rst_wr_en",     80'(ifs.wr_en),     80'(0));
      check("p6_rst_len_rst",   80'(ifs.len_rst),   80'(0));
      check("p6_rst_done",      80'(ifs.done),      80'(0));
      check("p6_rst_wr_data",   80'(ifs.wr_data),   80'(0));
      check("p6_rst_pkt_words", 80'(ifs.pkt_words), 80'(0));
      check("p6_rst_overflow",  80'(ifs.overflow),  80'(0));
      @(negedge clk);
      qs.delete(); qb.delete(); lens = 0;
      rst_n = 1'b1;
      send(32'hABCD_0001, 1'b0);
      send(32'hABCD_0002, 1'b1);
      @(negedge clk);
      check("p7_len_rst",   80'(lens),          80'(1));
      check("p7_nwrites",   80'(qs.size()),     80'(1));
      chk_s("p7_w0", 0, 0, {32'hABCD_0001, 32'hABCD_0002});
      check("p7_pkt_words", 80'(ifs.pkt_words), 80'(2));
      check("p7_done",      80'(ifs.done),      80'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/packet_snooper.md
# packet_snooper

Ingress write agent for the packet memory. It accepts a 32-bit word stream (valid/ready/last) and packs consecutive word pairs into 64-bit dual-word writes at even addresses of the packet RAM. It clears the RAM length tracker at packet start and reports completion, word count and overflow to the buffer-management logic that owns the RAM. It sits directly upstream of the packet RAM write port.

## Interface
- PORT_ADDR_WIDTH, 10, packet RAM word-address width; DEPTH = 2**PORT_ADDR_WIDTH words
- PORT_DATA_WIDTH, 32, stream word width; RAM write data is 2*PORT_DATA_WIDTH
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_ready  in  1  level from the buffer owner: the RAM is free to fill
- in_data  in  PORT_DATA_WIDTH  stream word
- in_valid  in  1  stream word valid
- in_last  in  1  final word of packet, qualified by in_valid
- in_ready  out  1  stream ready
- wr_addr  out  PORT_ADDR_WIDTH  RAM write address, always even
- wr_data  out  2*PORT_DATA_WIDTH  {word at wr_addr, word at wr_addr+1}
- wr_en  out  1  RAM write strobe
- len_rst  out  1  one-cycle pulse that clears the RAM length tracker
- done  out  1  packet complete; level
- pkt_words  out  PORT_ADDR_WIDTH+1  words received in the current packet, saturating at DEPTH
- overflow  out  1  sticky per packet: words were dropped

## Operation
- A beat is accepted when in_valid && in_ready.
- States: IDLE, EVEN, ODD, DONE. Reset puts the block in IDLE.
- IDLE:
  - in_ready=0.
  - If mem_ready=1: pulse len_rst, clear wr_addr, pkt_words and overflow, go to EVEN.
- EVEN:
  - in_ready=1.
  - On a beat with in_last=0: store the word in the hold register, go to ODD.
  - On a beat with in_last=1: write {in_data, 0} at the current address, go to DONE.
- ODD:
  - in_ready=1.
  - On a beat: write {hold, in_data} at the current address, then advance the address by 2.
  - Go to DONE if in_last=1, otherwise go to EVEN.
- DONE:
  - done=1, in_ready=0.
  - Stays in DONE while mem_ready=1.
  - Goes to IDLE when mem_ready=0, with done=0 in IDLE.
- pkt_words increments on every accepted beat and saturates at DEPTH.
- Overflow:
  - After the pair at address DEPTH-2 is written, further words are accepted but not written, and overflow is set.
  - The address does not wrap.
  - Packets still terminate only on in_last.
- A lone final word on the even slot writes zeros into the odd slot.
- mem_ready falling during EVEN or ODD has no effect. The block finishes the packet, then enters DONE and leaves it the next cycle.
- Asynchronous reset mid-packet: the block returns to IDLE and all outputs go to their reset values. The partial packet is abandoned.

## Timing
- Reset values:
  - in_ready, wr_en, len_rst, done, overflow: 0
  - wr_addr: 0
  - wr_data: 0
  - pkt_words: 0
- wr_addr, wr_data and wr_en are registered. A write appears on the cycle after the accepting edge and lasts one cycle.
- len_rst is registered. It is high for the single cycle after IDLE samples mem_ready=1, and the first beat can be accepted in that same cycle.
- in_ready is decoded from the state with no dependency on in_valid. Full throughput is one word per cycle.
- done rises on the cycle after the last write strobe, so the RAM holds the complete packet when done is seen. pkt_words and overflow are stable while done=1.
- IDLE to EVEN takes one cycle. A new packet can start no earlier than 2 cycles after mem_ready drops.

## Test plan
- Four-word packet A,B,C,D with mem_ready=1 and in_valid held high:
  - len_rst is pulsed once.
  - Writes {A,B}@0, then {C,D}@2 on consecutive-pair cycles.
  - done=1 and pkt_words=4.
- Three-word packet X,Y,Z:
  - Writes {X,Y}@0, then {Z,0}@2.
  - pkt_words=3, overflow=0.
- Single-word packet with in_last on the first beat: one write {W,0}@0, done on the next cycle, pkt_words=1.
- PORT_ADDR_WIDTH=3 (DEPTH=8) with a 10-word packet:
  - Writes at addresses 0, 2, 4, 6 only.
  - Words 9 and 10 are accepted but not written.
  - overflow=1, pkt_words=8.
  - The next packet clears overflow.
- Backpressure and handshake:
  - Random gaps on in_valid produce identical writes.
  - in_ready=0 while in IDLE or DONE.
  - done holds until mem_ready drops; a second packet then repeats len_rst and starts at address 0.
- rst_n asserted mid-packet after 3 beats: all outputs go to 0 immediately, the block sits in IDLE, and the next packet starts cleanly at address 0.
